// File: rtl/wired_issue_pkg.sv
// wired_issue_pkg: shared sizes, tag/broadcast/select types and a priority helper for the issue scheduler
package wired_issue_pkg;
    localparam int TAG_W          = 6;
    localparam int WAKEUP_SRC_CNT = 4;
    localparam int OPERAND_CNT    = 2;
    localparam int SB_DEPTH       = 2 ** TAG_W;
    typedef logic [TAG_W-1:0] tag_t;
    typedef struct packed {
        logic valid;
        tag_t tag;
    } wkup_bcast_t;
    typedef struct packed {
        logic used;
        tag_t tag;
    } sel_req_t;
    function automatic logic [WAKEUP_SRC_CNT-1:0] lowest_one(input logic [WAKEUP_SRC_CNT-1:0] v);
        return v & (~v + 1'b1);
    endfunction
endpackage

// File: rtl/wired_wkup_sched_if.sv
// wired_wkup_sched_if: select, wakeup, allocation, flush and FU1 handoff signals of the scheduler
//   slave  = scheduler side, master = issue queue / rename / FU side
interface wired_wkup_sched_if;
    import wired_issue_pkg::*;
    logic                                          sel_valid_i;
    logic [OPERAND_CNT-1:0]                        sel_use_i;
    logic [OPERAND_CNT-1:0][TAG_W-1:0]             sel_tag_i;
    logic                                          sel_grant_o;
    logic [WAKEUP_SRC_CNT-1:0]                     wkup_valid_i;
    logic [WAKEUP_SRC_CNT-1:0][TAG_W-1:0]          wkup_tag_i;
    logic                                          alloc_valid_i;
    logic [TAG_W-1:0]                              alloc_tag_i;
    logic                                          flush_i;
    logic [OPERAND_CNT-1:0][WAKEUP_SRC_CNT-1:0]    wkup_src_o;
    logic                                          fu1_ready_o;
    logic                                          iss_valid_o;
    logic                                          iss_ready_i;
    modport slave (
        input  sel_valid_i, sel_use_i, sel_tag_i, wkup_valid_i, wkup_tag_i,
        input  alloc_valid_i, alloc_tag_i, flush_i, iss_ready_i,
        output sel_grant_o, wkup_src_o, fu1_ready_o, iss_valid_o
    );
    modport master (
        output sel_valid_i, sel_use_i, sel_tag_i, wkup_valid_i, wkup_tag_i,
        output alloc_valid_i, alloc_tag_i, flush_i, iss_ready_i,
        input  sel_grant_o, wkup_src_o, fu1_ready_o, iss_valid_o
    );
endinterface

// File: rtl/wired_wkup_scoreboard.sv
// wired_wkup_scoreboard: physical-register ready bits, set by broadcasts, cleared by allocation
//   set_i     broadcast tags marking registers ready at the next edge
//   clr_*     allocated destination tag marked not-ready (wins over a same-edge set)
//   rd_tag_i  operand tags looked up; rd_rdy_o is 1 for ready tags and always for tag 0
module wired_wkup_scoreboard
    import wired_issue_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  wkup_bcast_t [WAKEUP_SRC_CNT-1:0] set_i,
    input  logic                             clr_valid_i,
    input  tag_t                             clr_tag_i,
    input  tag_t [OPERAND_CNT-1:0]           rd_tag_i,
    output logic [OPERAND_CNT-1:0]           rd_rdy_o
);
    logic [SB_DEPTH-1:0] sb_q;
    logic [SB_DEPTH-1:0] sb_d;
    always_comb begin
        sb_d = sb_q;
        for (int s = 0; s < WAKEUP_SRC_CNT; s++)
            if (set_i[s].valid) sb_d[set_i[s].tag] = 1'b1;
        if (clr_valid_i) sb_d[clr_tag_i] = 1'b0;
        sb_d[0] = 1'b1;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) sb_q <= '1;
        else     sb_q <= sb_d;
    for (genvar i = 0; i < OPERAND_CNT; i++) begin : g_rd
        assign rd_rdy_o[i] = sb_q[rd_tag_i[i]] | (rd_tag_i[i] == '0);
    end
endmodule

// File: rtl/wired_wkup_sched.sv
// wired_wkup_sched: operand ready/forward selection at SEL and the SEL->FU1 slot handoff
//   clk, rst  clock and asynchronous active-high reset
//   bus       select request/grant, result broadcasts, allocation, flush, forward selects, FU1 handshake
module wired_wkup_sched
    import wired_issue_pkg::*;
(
    input logic               clk,
    input logic               rst,
    wired_wkup_sched_if.slave bus
);
    wkup_bcast_t [WAKEUP_SRC_CNT-1:0]            bcast;
    sel_req_t    [OPERAND_CNT-1:0]               req;
    tag_t        [OPERAND_CNT-1:0]               rd_tag;
    logic        [OPERAND_CNT-1:0]               rdy;
    logic        [OPERAND_CNT-1:0]               ok;
    logic        [OPERAND_CNT-1:0][WAKEUP_SRC_CNT-1:0] hit;
    logic                                        fire;
    logic                                        iss_valid_q;
    logic                                        dup_bcast;
    for (genvar s = 0; s < WAKEUP_SRC_CNT; s++) begin : g_bc
        assign bcast[s] = {bus.wkup_valid_i[s], bus.wkup_tag_i[s]};
    end
    wired_wkup_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_i      (bcast),
        .clr_valid_i(bus.alloc_valid_i),
        .clr_tag_i  (bus.alloc_tag_i),
        .rd_tag_i   (rd_tag),
        .rd_rdy_o   (rdy)
    );
    // An operand is usable if unused, already ready, or its producer broadcasts this cycle.
    // Only not-yet-ready operands take the bypass; ready ones read the write-through register file.
    for (genvar i = 0; i < OPERAND_CNT; i++) begin : g_op
        assign req[i]    = {bus.sel_use_i[i], bus.sel_tag_i[i]};
        assign rd_tag[i] = req[i].tag;
        for (genvar s = 0; s < WAKEUP_SRC_CNT; s++) begin : g_hit
            assign hit[i][s] = bcast[s].valid && (bcast[s].tag == req[i].tag);
        end
        assign ok[i] = !req[i].used | rdy[i] | (|hit[i]);
        assign bus.wkup_src_o[i] = (fire && req[i].used && !rdy[i]) ? lowest_one(hit[i]) : '0;
    end
    assign bus.fu1_ready_o = !iss_valid_q | bus.iss_ready_i | bus.flush_i;
    assign fire            = bus.sel_valid_i & (&ok) & bus.fu1_ready_o & !bus.flush_i;
    assign bus.sel_grant_o = fire;
    assign bus.iss_valid_o = iss_valid_q;
    always_ff @(posedge clk or posedge rst)
        if (rst)                  iss_valid_q <= 1'b0;
        else if (bus.flush_i)     iss_valid_q <= 1'b0;
        else if (bus.fu1_ready_o) iss_valid_q <= fire;
    always_comb begin
        dup_bcast = 1'b0;
        for (int s = 0; s < WAKEUP_SRC_CNT; s++)
            for (int t = s + 1; t < WAKEUP_SRC_CNT; t++)
                if (bcast[s].valid && bcast[t].valid && bcast[s].tag == bcast[t].tag) dup_bcast = 1'b1;
    end
    a_single_producer: assert property (@(posedge clk) disable iff (rst) !dup_bcast);
endmodule

// File: tb/tb_wired_wkup_sched.sv
// tb_wired_wkup_sched: table-driven cycle vectors plus reset-mid-stall sequence for wired_wkup_sched
module tb_wired_wkup_sched;
    import wired_issue_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    wired_wkup_sched_if ifc();
    wired_wkup_sched dut (.clk(clk), .rst(rst), .bus(ifc.slave));
    typedef struct {
        logic       sv;
        logic [1:0] use_m;
        logic [5:0] t0, t1;
        logic [3:0] wv;
        logic [5:0] wt;
        logic       av;
        logic [5:0] at;
        logic       fl, ir;
        logic       eg;
        logic [7:0] es;
        logic       ef, ei;
    } vec_t;
    vec_t tbl[$];
    int n_cmp = 0;
    int n_bad = 0;
    function automatic vec_t mk(input logic sv, input logic [1:0] use_m, input logic [5:0] t0, t1,
                                input logic [3:0] wv, input logic [5:0] wt, input logic av,
                                input logic [5:0] at, input logic fl, ir, eg, input logic [7:0] es,
                                input logic ef, ei);
        vec_t v;
        v.sv = sv; v.use_m = use_m; v.t0 = t0; v.t1 = t1; v.wv = wv; v.wt = wt;
        v.av = av; v.at = at; v.fl = fl; v.ir = ir; v.eg = eg; v.es = es; v.ef = ef; v.ei = ei;
        return v;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic drive(input vec_t v);
        ifc.sel_valid_i   = v.sv;
        ifc.sel_use_i     = v.use_m;
        ifc.sel_tag_i     = {v.t1, v.t0};
        ifc.wkup_valid_i  = v.wv;
        ifc.wkup_tag_i    = {4{v.wt}};
        ifc.alloc_valid_i = v.av;
        ifc.alloc_tag_i   = v.at;
        ifc.flush_i       = v.fl;
        ifc.iss_ready_i   = v.ir;
    endtask
    task automatic check(input string nm, input vec_t v);
        chk({nm, " grant"}, 32'(ifc.sel_grant_o), 32'(v.eg));
        chk({nm, " wkup_src"}, 32'(ifc.wkup_src_o), 32'(v.es));
        chk({nm, " fu1_ready"}, 32'(ifc.fu1_ready_o), 32'(v.ef));
        chk({nm, " iss_valid"}, 32'(ifc.iss_valid_o), 32'(v.ei));
    endtask
    initial begin
        vec_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        //        sv use t0  t1  wv       wt  av at  fl ir  eg es     ef ei
        tbl.push_back(mk(1, 3, 5,  7,  4'b0000, 0,  0, 0,  0, 1, 1, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0,  4'b0000, 0,  1, 9,  0, 1, 0, 8'h00, 1, 1));
        tbl.push_back(mk(1, 1, 9,  0,  4'b0000, 0,  0, 0,  0, 1, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 1, 9,  0,  4'b0100, 9,  0, 0,  0, 1, 1, 8'h04, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0,  4'b0000, 0,  1, 9,  0, 1, 0, 8'h00, 1, 1));
        tbl.push_back(mk(1, 2, 0,  9,  4'b0010, 9,  0, 0,  0, 1, 1, 8'h20, 1, 0));
        tbl.push_back(mk(1, 3, 9,  9,  4'b0000, 0,  0, 0,  0, 1, 1, 8'h00, 1, 1));
        tbl.push_back(mk(1, 3, 5,  7,  4'b0000, 0,  0, 0,  0, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 3, 5,  7,  4'b0000, 0,  0, 0,  0, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 3, 5,  7,  4'b0000, 0,  0, 0,  0, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 3, 5,  7,  4'b0000, 0,  0, 0,  0, 1, 1, 8'h00, 1, 1));
        tbl.push_back(mk(0, 0, 0,  0,  4'b0001, 12, 1, 12, 0, 1, 0, 8'h00, 1, 1));
        tbl.push_back(mk(1, 1, 12, 0,  4'b0000, 0,  0, 0,  0, 1, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 3, 0,  0,  4'b1000, 0,  0, 0,  0, 1, 1, 8'h00, 1, 0));
        tbl.push_back(mk(1, 3, 0,  5,  4'b0000, 0,  1, 0,  0, 1, 1, 8'h00, 1, 1));
        tbl.push_back(mk(1, 3, 0,  0,  4'b0000, 0,  0, 0,  0, 1, 1, 8'h00, 1, 1));
        tbl.push_back(mk(1, 3, 5,  7,  4'b0000, 0,  0, 0,  1, 0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(1, 0, 12, 12, 4'b0000, 0,  0, 0,  0, 0, 1, 8'h00, 1, 0));
        tbl.push_back(mk(1, 1, 12, 0,  4'b1000, 12, 0, 0,  0, 1, 1, 8'h08, 1, 1));
        drive(z);
        #2;
        chk("reset iss_valid", 32'(ifc.iss_valid_o), 0);
        chk("reset grant", 32'(ifc.sel_grant_o), 0);
        chk("reset wkup_src", 32'(ifc.wkup_src_o), 0);
        #10 rst = 1'b0;
        foreach (tbl[k]) begin
            drive(tbl[k]);
            #1;
            check($sformatf("row%0d", k), tbl[k]);
            @(posedge clk);
            #1;
        end
        // Stall with a full slot while allocating tag 20, then reset mid-stall.
        drive(mk(1, 1, 5, 0, 4'b0000, 0, 1, 20, 0, 0, 0, 8'h00, 0, 1));
        #1;
        check("stall", mk(1, 1, 5, 0, 0, 0, 1, 20, 0, 0, 0, 8'h00, 0, 1));
        @(posedge clk);
        #1;
        chk("stall hold iss_valid", 32'(ifc.iss_valid_o), 1);
        drive(mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
        #2 rst = 1'b1;
        #1;
        chk("rst mid-stall iss_valid", 32'(ifc.iss_valid_o), 0);
        chk("rst mid-stall fu1_ready", 32'(ifc.fu1_ready_o), 1);
        chk("rst mid-stall grant", 32'(ifc.sel_grant_o), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(mk(1, 1, 20, 0, 4'b0000, 0, 0, 0, 0, 1, 1, 8'h00, 1, 0));
        #1;
        check("post-reset sb", mk(1, 1, 20, 0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 1, 0));
        @(posedge clk);
        #1;
        drive(z);
        #1;
        chk("post-reset iss_valid", 32'(ifc.iss_valid_o), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
